// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared types and constants for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  // Default reset vector; any override must stay 4-byte aligned.
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Size of one instruction word in bytes (PC increment).
  localparam int INSTR_BYTES = 4;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_ISSUE     = 2'd0,
    ST_WAIT_RESP = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_FAULT     = 2'd3
  } fetch_state_t;

  // Word handed to decode.
  typedef logic [31:0] instr_packet_t;

  // A redirect target is legal only when it is word aligned.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_out_reg
// Purpose  : Holding register between fetch and decode (valid/instr/pc).
//            Flush beats load beats consume.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit_out_reg
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  instr_packet_t   i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_consume,
  input  logic            i_flush,
  output logic            o_valid,
  output instr_packet_t   o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  instr_packet_t   r_instr;
  logic [XLEN-1:0] r_pc;

  // Capture a fetched word, drop it on flush, clear valid once decode takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the PC, issues one instruction
//            memory request at a time, buffers the returned word for decode
//            and handles redirects, including misaligned-target faults.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pc_input_sel,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            decode_ready,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_pc;

  logic            w_out_valid;
  instr_packet_t   w_out_instr;
  logic [XLEN-1:0] w_out_pc;
  logic            w_consume;
  logic            w_req_valid;
  logic            w_handshake;
  logic            w_redirect;
  logic            w_target_ok;
  logic            w_load;
  logic [XLEN-1:0] w_pc_inc;

  // A new request is allowed only when the holding register is free now or
  // frees this cycle; FAULT is terminal so redirects there are ignored.
  assign w_consume   = w_out_valid && decode_ready;
  assign w_req_valid = !reset && (r_state == ST_ISSUE) && (!w_out_valid || w_consume);
  assign w_handshake = w_req_valid && imem_req_ready;
  assign w_redirect  = pc_input_sel && (r_state != ST_FAULT);
  assign w_target_ok = is_word_aligned(branch_target[1:0]);
  assign w_load      = (r_state == ST_WAIT_RESP) && imem_resp_valid && !w_redirect;
  assign w_pc_inc    = r_pc + XLEN'(INSTR_BYTES);

  fetch_unit_out_reg #(
    .XLEN (XLEN)
  ) u_out_reg (
    .clk       (clock),
    .rst       (reset),
    .i_load    (w_load),
    .i_instr   (imem_resp_data),
    .i_pc      (r_pc),
    .i_consume (w_consume),
    .i_flush   (w_redirect),
    .o_valid   (w_out_valid),
    .o_instr   (w_out_instr),
    .o_pc      (w_out_pc)
  );

  // Fetch sequencer: PC update, request tracking, stale-response drain, fault.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_ISSUE;
      r_pc       <= RESET_VECTOR;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (w_redirect) begin
      r_pc <= branch_target;
      if (!w_target_ok) begin
        r_fault    <= 1'b1;
        r_fault_pc <= branch_target;
        r_state    <= ST_FAULT;
      end else begin
        case (r_state)
          // A request accepted this very cycle still owes a response.
          ST_ISSUE:     r_state <= w_handshake ? ST_DRAIN : ST_ISSUE;
          // A response landing with the redirect is simply dropped.
          ST_WAIT_RESP: r_state <= imem_resp_valid ? ST_ISSUE : ST_DRAIN;
          ST_DRAIN:     r_state <= imem_resp_valid ? ST_ISSUE : ST_DRAIN;
          default:      r_state <= r_state;
        endcase
      end
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_handshake) r_state <= ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          if (imem_resp_valid) begin
            r_pc    <= w_pc_inc;
            r_state <= ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (imem_resp_valid) r_state <= ST_ISSUE;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign instr          = w_out_instr;
  assign instr_pc       = w_out_pc;
  assign instr_valid    = w_out_valid;
  assign fetch_fault    = r_fault;
  assign fault_pc       = r_fault_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a small
//            instruction memory model of selectable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pc_input_sel = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready = 1'b1;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int outstanding = 0;
  int orphan_resp = 0;
  int mem_lat = 1;

  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .pc_input_sel    (pc_input_sel),
    .branch_target   (branch_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .decode_ready    (decode_ready),
    .fetch_fault     (fetch_fault),
    .fault_pc        (fault_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: answers each accepted request after mem_lat cycles.
  always @(posedge clock) begin
    if (reset) begin
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
      pend            <= 1'b0;
      cnt             <= 0;
    end else begin
      imem_resp_valid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= mem_word(paddr);
          pend            <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        if (mem_lat == 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= mem_word(imem_req_addr);
        end else begin
          pend  <= 1'b1;
          paddr <= imem_req_addr;
          cnt   <= mem_lat - 1;
        end
      end
    end
  end

  // Handshake counter and a response-without-request watchdog.
  always @(posedge clock) begin
    if (reset) begin
      outstanding <= 0;
    end else begin
      if (imem_req_valid && imem_req_ready) hs_count <= hs_count + 1;
      if (imem_resp_valid && outstanding == 0) orphan_resp <= orphan_resp + 1;
      outstanding <= outstanding + ((imem_req_valid && imem_req_ready) ? 1 : 0)
                                 - (imem_resp_valid ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);

    // Memory stalls the first request for 3 cycles
    reset = 1'b0;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_req_addr", imem_req_addr, 32'h0);
      chk("stall_no_hs", 32'(hs_count), 32'd0);
    end
    imem_req_ready = 1'b1;
    step();
    chk("stall_hs", 32'(hs_count), 32'd1);
    chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
    chk("wait_instr_valid", 32'(instr_valid), 32'd0);

    // Streaming with 1-cycle memory: one instruction every 2 cycles
    step();
    chk("s0_valid", 32'(instr_valid), 32'd1);
    chk("s0_pc", instr_pc, 32'h0);
    chk("s0_instr", instr, 32'h1357_9BDF);
    chk("s0_next_addr", imem_req_addr, 32'h4);
    chk("s0_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    chk("s1_gap", 32'(instr_valid), 32'd0);
    step();
    chk("s1_valid", 32'(instr_valid), 32'd1);
    chk("s1_pc", instr_pc, 32'h4);
    chk("s1_instr", instr, 32'h1357_9BDB);
    chk("s1_next_addr", imem_req_addr, 32'h8);
    step();
    chk("s2_gap", 32'(instr_valid), 32'd0);
    step();
    chk("s2_valid", 32'(instr_valid), 32'd1);
    chk("s2_pc", instr_pc, 32'h8);
    chk("s2_instr", instr, 32'h1357_9BD7);

    // Decode back-pressure for 5 cycles holds pc 8 and blocks requests
    decode_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_pc", instr_pc, 32'h8);
      chk("hold_instr", instr, 32'h1357_9BD7);
      chk("hold_no_req", 32'(imem_req_valid), 32'd0);
      chk("hold_hs", 32'(hs_count), 32'd3);
    end
    decode_ready = 1'b1;
    #1;
    chk("release_req_valid", 32'(imem_req_valid), 32'd1);
    chk("release_req_addr", imem_req_addr, 32'hC);
    step();
    chk("s3_gap", 32'(instr_valid), 32'd0);
    chk("s3_hs", 32'(hs_count), 32'd4);
    step();
    chk("s3_valid", 32'(instr_valid), 32'd1);
    chk("s3_pc", instr_pc, 32'hC);
    chk("s3_instr", instr, 32'h1357_9BD3);
    chk("s3_next_addr", imem_req_addr, 32'h10);

    // Redirect to 0x100 while waiting on a slow response for 0x10
    mem_lat = 3;
    step();
    chk("slow_hs", 32'(hs_count), 32'd5);
    pc_input_sel  = 1'b1;
    branch_target = 32'h100;
    step();
    pc_input_sel = 1'b0;
    chk("drain_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drain_req_addr", imem_req_addr, 32'h100);
    chk("drain_instr_valid", 32'(instr_valid), 32'd0);
    step();
    chk("drain_still", 32'(imem_req_valid), 32'd0);
    step();
    chk("drained_req_valid", 32'(imem_req_valid), 32'd1);
    chk("drained_req_addr", imem_req_addr, 32'h100);
    chk("stale_dropped", 32'(instr_valid), 32'd0);
    mem_lat = 1;
    step();
    step();
    chk("redir_valid", 32'(instr_valid), 32'd1);
    chk("redir_pc", instr_pc, 32'h100);
    chk("redir_instr", instr, 32'h1357_9ADF);
    chk("redir_next_addr", imem_req_addr, 32'h104);

    // Redirect coinciding with a handshake in ISSUE, then PC wrap
    pc_input_sel  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    pc_input_sel = 1'b0;
    chk("hs_redir_count", 32'(hs_count), 32'd7);
    chk("hs_redir_flush", 32'(instr_valid), 32'd0);
    chk("hs_redir_req_valid", 32'(imem_req_valid), 32'd0);
    chk("hs_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    chk("top_req_valid", 32'(imem_req_valid), 32'd1);
    chk("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("top_no_stale", 32'(instr_valid), 32'd0);
    step();
    step();
    chk("top_valid", 32'(instr_valid), 32'd1);
    chk("top_pc", instr_pc, 32'hFFFF_FFFC);
    chk("top_instr", instr, 32'hECA8_6423);
    chk("wrap_addr", imem_req_addr, 32'h0);
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);

    // Misaligned redirect: sticky fault, no more requests
    pc_input_sel  = 1'b1;
    branch_target = 32'h202;
    step();
    pc_input_sel  = 1'b0;
    branch_target = 32'h0;
    chk("fault_flag", 32'(fetch_fault), 32'd1);
    chk("fault_pc", fault_pc, 32'h202);
    chk("fault_req_valid", 32'(imem_req_valid), 32'd0);
    chk("fault_instr_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault_idle_req", 32'(imem_req_valid), 32'd0);
      chk("fault_sticky", 32'(fetch_fault), 32'd1);
      chk("fault_idle_instr", 32'(instr_valid), 32'd0);
    end
    chk("fault_hs_frozen", 32'(hs_count), 32'd9);

    // Reset clears the fault and restarts at the reset vector
    reset = 1'b1;
    step();
    chk("rst2_fault", 32'(fetch_fault), 32'd0);
    chk("rst2_fault_pc", fault_pc, 32'h0);
    chk("rst2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst2_req_addr", imem_req_addr, 32'h0);
    chk("rst2_instr_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst2_req_resume", 32'(imem_req_valid), 32'd1);
    step();
    chk("rst2_hs", 32'(hs_count), 32'd10);
    step();
    chk("rst2_valid", 32'(instr_valid), 32'd1);
    chk("rst2_pc", instr_pc, 32'h0);
    chk("rst2_instr", instr, 32'h1357_9BDF);

    chk("no_orphan_resp", 32'(orphan_resp), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
